// File: rtl/stream_rr_arbiter_if.sv
// Valid/ready stream bundle carrying N lanes of {ctrl, data}.
// Lane k occupies ctrl[k*CTRL_BITS +: CTRL_BITS] and data[k*DATA_BITS +: DATA_BITS].
interface stream_rr_arbiter_if #(
  parameter int N         = 1,
  parameter int CTRL_BITS = 8,
  parameter int DATA_BITS = 32
);
  logic [N*CTRL_BITS-1:0] ctrl;
  logic [N*DATA_BITS-1:0] data;
  logic [N-1:0]           valid;
  logic [N-1:0]           ready;

  modport master (output ctrl, output data, output valid, input ready);
  modport slave  (input ctrl, input data, input valid, output ready);
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NUM valid/ready streams onto one registered output,
// holding the grant for a burst until the last beat or MAX_BURST beats.
module stream_rr_arbiter #(
  parameter int NUM       = 4,
  parameter int CTRL_BITS = 8,
  parameter int DATA_BITS = 32,
  parameter int LAST_BIT  = 0,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  stream_rr_arbiter_if.slave      s,
  stream_rr_arbiter_if.master     t,
  output logic [$clog2(NUM)-1:0]  grant_id,
  output logic                    busy
);

  localparam int IDW   = $clog2(NUM);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [IDW-1:0]       ptr_r;
  logic [IDW-1:0]       grant_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_inc_s;
  logic                 t_valid_r;
  logic [CTRL_BITS-1:0] t_ctrl_r;
  logic [DATA_BITS-1:0] t_data_r;

  logic                 slot_free_s;
  logic [IDW-1:0]       win_s;
  logic                 win_found_s;
  logic [IDW-1:0]       sel_s;
  logic [IDW-1:0]       ptr_nxt_s;
  logic [NUM-1:0]       ready_s;
  logic                 accept_s;
  logic [CTRL_BITS-1:0] sel_ctrl_s;
  logic [DATA_BITS-1:0] sel_data_s;
  logic                 release_s;

  assign slot_free_s = ~t_valid_r | t.ready[0];
  assign sel_s       = (state_r == LOCKED) ? grant_r : win_s;
  assign sel_ctrl_s  = s.ctrl[sel_s*CTRL_BITS +: CTRL_BITS];
  assign sel_data_s  = s.data[sel_s*DATA_BITS +: DATA_BITS];
  assign accept_s    = |(ready_s & s.valid);
  assign cnt_inc_s   = cnt_r + CNT_W'(1);
  assign ptr_nxt_s   = (sel_s == IDW'(NUM - 1)) ? IDW'(0) : sel_s + IDW'(1);

  // Circular search for the first valid requester starting at the rr pointer.
  always_comb begin
    win_s       = '0;
    win_found_s = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (!win_found_s && s.valid[(int'(ptr_r) + i) % NUM]) begin
        win_s       = IDW'((int'(ptr_r) + i) % NUM);
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // A burst ends on its last beat, or when the beat budget is used up.
  always_comb begin
    release_s = 1'b0;
    case (state_r)
      IDLE:    release_s = sel_ctrl_s[LAST_BIT] | (MAX_BURST == 1);
      LOCKED:  release_s = sel_ctrl_s[LAST_BIT] | (cnt_inc_s == CNT_W'(MAX_BURST));
      default: release_s = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !release_s) state_nxt_s = LOCKED;
        else                        state_nxt_s = IDLE;
      end
      LOCKED: begin
        if (accept_s && release_s) state_nxt_s = IDLE;
        else                       state_nxt_s = LOCKED;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Ready goes to exactly one requester: the winner when idle, the owner when locked.
  always_comb begin
    ready_s = '0;
    if (rst) begin
      ready_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_found_s) ready_s[win_s] = slot_free_s;
          else             ready_s        = '0;
        end
        LOCKED:  ready_s[grant_r] = slot_free_s;
        default: ready_s = '0;
      endcase
    end
  end

  // Grant, pointer and beat counter bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r <= '0;
      ptr_r   <= '0;
      cnt_r   <= '0;
    end else if (accept_s) begin
      grant_r <= sel_s;
      if (release_s) ptr_r <= ptr_nxt_s;
      if (state_r == IDLE)  cnt_r <= CNT_W'(1);
      else if (release_s)   cnt_r <= '0;
      else                  cnt_r <= cnt_inc_s;
    end
  end

  // Output register: load on accept, drain on downstream ready, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_valid_r <= 1'b0;
      t_ctrl_r  <= '0;
      t_data_r  <= '0;
    end else if (accept_s) begin
      t_valid_r <= 1'b1;
      t_ctrl_r  <= sel_ctrl_s;
      t_data_r  <= sel_data_s;
    end else if (t.ready[0]) begin
      t_valid_r <= 1'b0;
    end
  end

  assign s.ready  = ready_s;
  assign t.valid  = t_valid_r;
  assign t.ctrl   = t_ctrl_r;
  assign t.data   = t_data_r;
  assign grant_id = grant_r;
  assign busy     = (state_r == LOCKED);

endmodule
